// File: rtl/fpnew_pkg.sv
// Shared FP types and helpers: formats, classification record, fclass encoding.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    typedef logic [9:0] classmask_t;

    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    // Record of an operand that failed the NaN-boxing check: canonical qNaN.
    localparam fp_info_t UNBOXED_INFO = '{is_nan: 1'b1, is_quiet: 1'b1, default: 1'b0};

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd32;
            FP64:    return 32'd64;
            FP16:    return 32'd16;
            FP8:     return 32'd8;
            FP16ALT: return 32'd16;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd8;
            FP64:    return 32'd11;
            FP16:    return 32'd5;
            FP8:     return 32'd5;
            FP16ALT: return 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd23;
            FP64:    return 32'd52;
            FP16:    return 32'd10;
            FP8:     return 32'd2;
            FP16ALT: return 32'd7;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_enabled_fmt(logic [NUM_FP_FORMATS-1:0] mask, fp_format_e fmt);
        logic [7:0] mask_ext;
        mask_ext = {3'b000, mask};
        return mask_ext[fmt];
    endfunction

    function automatic classmask_t fclass_encode(fp_info_t info, logic sign);
        classmask_t m;
        m = 10'h000;
        if (info.is_signalling)     m[CLS_SNAN] = 1'b1;
        else if (info.is_nan)       m[CLS_QNAN] = 1'b1;
        else if (info.is_inf)       m[sign ? CLS_NEG_INF  : CLS_POS_INF]  = 1'b1;
        else if (info.is_normal)    m[sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        else if (info.is_subnormal) m[sign ? CLS_NEG_SUB  : CLS_POS_SUB]  = 1'b1;
        else if (info.is_zero)      m[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
        else                        m[CLS_QNAN] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/fpnew_elastic_stage.sv
// One valid/ready register slice with flush and synchronous reset.
module fpnew_elastic_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             valid_r;
    logic [Width-1:0] data_r;

    // Load when empty or when the next stage takes our word this cycle; never during flush/reset.
    assign ready_o = (~valid_r | ready_i) & ~flush_i & ~rst_i;
    assign valid_o = valid_r;
    assign data_o  = data_r;

    // Slice state: reset clears everything, flush drops valid, otherwise advance on load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            data_r  <= {Width{1'b0}};
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (ready_o) begin
            valid_r <= valid_i;
            if (valid_i) begin
                data_r <= data_i;
            end
        end
    end

endmodule

// File: rtl/fpnew_multifmt_classifier.sv
// Multi-format NaN-box check and operand classification behind an elastic pipeline.
module fpnew_multifmt_classifier
    import fpnew_pkg::*;
#(
    parameter int unsigned                      FLEN        = 64,
    parameter int unsigned                      NumOperands = 3,
    parameter logic [NUM_FP_FORMATS-1:0]        FpFmtMask   = 5'b11111,
    parameter int unsigned                      NumPipeRegs = 1,
    parameter int unsigned                      TagWidth    = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumOperands-1:0][FLEN-1:0]    operands_i,
    input  logic [2:0]                          src_fmt_i,
    input  logic [TagWidth-1:0]                 tag_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic                                flush_i,
    output fp_info_t [NumOperands-1:0]          info_o,
    output classmask_t [NumOperands-1:0]        class_o,
    output logic                                fmt_err_o,
    output logic [TagWidth-1:0]                 tag_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                busy_o
);

    // A format is usable only if enabled and it fits in the container.
    function automatic logic [NUM_FP_FORMATS-1:0] usable_fmts();
        logic [NUM_FP_FORMATS-1:0] v;
        for (int f = 0; f < NUM_FP_FORMATS; f++) begin
            v[f] = FpFmtMask[f] && (fp_width(fp_format_e'(3'(f))) <= FLEN);
        end
        return v;
    endfunction

    localparam logic [NUM_FP_FORMATS-1:0] FmtUsable = usable_fmts();
    localparam int unsigned PayloadW = NumOperands * ($bits(fp_info_t) + 10) + 1 + TagWidth;

    fp_info_t [NumOperands-1:0]   fmt_info_s [NUM_FP_FORMATS];
    logic     [NumOperands-1:0]   fmt_sign_s [NUM_FP_FORMATS];
    fp_info_t [NumOperands-1:0]   sel_info_s;
    logic     [NumOperands-1:0]   sel_sign_s;
    classmask_t [NumOperands-1:0] class_s;
    logic [7:0]                   fmt_ok_ext_s;
    logic                         fmt_err_s;

    assign fmt_ok_ext_s = {3'b000, FmtUsable};
    assign fmt_err_s    = ~fmt_ok_ext_s[src_fmt_i];

    for (genvar f = 0; f < NUM_FP_FORMATS; f++) begin : g_fmt
        localparam fp_format_e  Fmt = fp_format_e'(3'(f));
        localparam int unsigned W   = fp_width(Fmt);
        localparam int unsigned EB  = exp_bits(Fmt);
        localparam int unsigned MB  = man_bits(Fmt);
        if (FmtUsable[f]) begin : g_dec
            // Ones in the format's own bits so only the box bits above W are tested.
            localparam logic [FLEN-1:0] LowMask = {FLEN{1'b1}} >> (FLEN - W);
            for (genvar o = 0; o < NumOperands; o++) begin : g_op
                logic [EB-1:0] exp_s;
                logic [MB-1:0] mant_s;
                logic          boxed_s, exp_zero_s, exp_ones_s, mant_zero_s;
                assign exp_s       = operands_i[o][MB +: EB];
                assign mant_s      = operands_i[o][MB-1:0];
                assign boxed_s     = &(operands_i[o] | LowMask);
                assign exp_zero_s  = ~|exp_s;
                assign exp_ones_s  = &exp_s;
                assign mant_zero_s = ~|mant_s;
                assign fmt_sign_s[f][o]                 = operands_i[o][W-1];
                assign fmt_info_s[f][o].is_boxed        = boxed_s;
                assign fmt_info_s[f][o].is_normal       = boxed_s & ~exp_zero_s & ~exp_ones_s;
                assign fmt_info_s[f][o].is_zero         = boxed_s & exp_zero_s & mant_zero_s;
                assign fmt_info_s[f][o].is_subnormal    = boxed_s & exp_zero_s & ~mant_zero_s;
                assign fmt_info_s[f][o].is_inf          = boxed_s & exp_ones_s & mant_zero_s;
                assign fmt_info_s[f][o].is_nan          = ~boxed_s | (exp_ones_s & ~mant_zero_s);
                assign fmt_info_s[f][o].is_signalling   = boxed_s & exp_ones_s & ~mant_zero_s & ~mant_s[MB-1];
                assign fmt_info_s[f][o].is_quiet        = fmt_info_s[f][o].is_nan & ~fmt_info_s[f][o].is_signalling;
            end
        end else begin : g_off
            assign fmt_info_s[f] = {NumOperands{UNBOXED_INFO}};
            assign fmt_sign_s[f] = {NumOperands{1'b0}};
        end
    end

    // Pick the decode of the selected format; unusable formats read as unboxed.
    always_comb begin
        sel_info_s = {NumOperands{UNBOXED_INFO}};
        sel_sign_s = {NumOperands{1'b0}};
        if (!fmt_err_s) begin
            case (src_fmt_i)
                3'd0:    begin sel_info_s = fmt_info_s[0]; sel_sign_s = fmt_sign_s[0]; end
                3'd1:    begin sel_info_s = fmt_info_s[1]; sel_sign_s = fmt_sign_s[1]; end
                3'd2:    begin sel_info_s = fmt_info_s[2]; sel_sign_s = fmt_sign_s[2]; end
                3'd3:    begin sel_info_s = fmt_info_s[3]; sel_sign_s = fmt_sign_s[3]; end
                3'd4:    begin sel_info_s = fmt_info_s[4]; sel_sign_s = fmt_sign_s[4]; end
                default: begin sel_info_s = {NumOperands{UNBOXED_INFO}}; sel_sign_s = {NumOperands{1'b0}}; end
            endcase
        end else begin
            sel_info_s = {NumOperands{UNBOXED_INFO}};
            sel_sign_s = {NumOperands{1'b0}};
        end
    end

    // One-hot fclass mask per operand.
    always_comb begin
        class_s = {NumOperands{10'h000}};
        for (int o = 0; o < NumOperands; o++) begin
            class_s[o] = fclass_encode(sel_info_s[o], sel_sign_s[o]);
        end
    end

    // Elastic chain: index 0 is the input side, index NumPipeRegs the output side.
    logic [NumPipeRegs:0] valid_s;
    logic [NumPipeRegs:0] ready_s;
    logic [PayloadW-1:0]  data_s [NumPipeRegs+1];

    assign valid_s[0]           = in_valid_i;
    assign data_s[0]            = {tag_i, fmt_err_s, class_s, sel_info_s};
    assign ready_s[NumPipeRegs] = out_ready_i;

    for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
        fpnew_elastic_stage #(.Width(PayloadW)) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .valid_i (valid_s[k]),
            .ready_o (ready_s[k]),
            .data_i  (data_s[k]),
            .valid_o (valid_s[k+1]),
            .ready_i (ready_s[k+1]),
            .data_o  (data_s[k+1])
        );
    end

    if (NumPipeRegs == 0) begin : g_busy_none
        assign busy_o = 1'b0;
    end else begin : g_busy
        assign busy_o = |valid_s[NumPipeRegs:1];
    end

    assign in_ready_o  = ready_s[0];
    assign out_valid_o = valid_s[NumPipeRegs];
    assign {tag_o, fmt_err_o, class_o, info_o} = data_s[NumPipeRegs];

endmodule

// File: doc/fpnew_multifmt_classifier.md
# fpnew_multifmt_classifier

Pipelined, multi-format successor to the single-format operand classifier. Per operand it checks NaN-boxing against a runtime-selected source format inside an FLEN-wide register. It produces the `fp_info_t` classification record and the 10-bit RISC-V `fclass` mask. Results travel through a configurable number of elastic valid/ready stages with a sideband tag. It sits between the FP register-file read and the FPU op-group dispatch, and also backs `FCLASS.*`.

## Interface
- `FLEN`, 64: operand container width; must be ≥ widest enabled format.
- `NumOperands`, 3: operands classified per transaction.
- `FpFmtMask`, 5'b11111: enable bit per `fp_format_e` (FP32=0, FP64=1, FP16=2, FP8=3, FP16ALT=4).
- `NumPipeRegs`, 1: elastic register stages, 0..4; 0 = combinational.
- `TagWidth`, 8: sideband tag width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `operands_i`  in  NumOperands×FLEN  raw register values.
- `src_fmt_i`  in  3  `fp_format_e` of all operands.
- `tag_i`  in  TagWidth  sideband, passed unmodified.
- `in_valid_i`  in  1  transaction offered.
- `in_ready_o`  out  1  transaction accepted when valid && ready.
- `flush_i`  in  1  kill all in-flight transactions.
- `info_o`  out  NumOperands×`fp_info_t`  classification record.
- `class_o`  out  NumOperands×10  one-hot fclass mask.
- `fmt_err_o`  out  1  `src_fmt` disabled or wider than FLEN.
- `tag_o`  out  TagWidth  tag of output transaction.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  downstream accepts.
- `busy_o`  out  1  any stage holds a valid transaction.

## Operation
- Widths and field sizes: FP32 32 (e8/m23), FP64 64 (e11/m52), FP16 16 (e5/m10), FP8 8 (e5/m2), FP16ALT 16 (e8/m7).
- Boxing: `is_boxed` = 1 iff bits [FLEN-1:W] are all ones, or W == FLEN.
- `fmt_err`: set when `src_fmt` is disabled in `FpFmtMask`, or its width exceeds FLEN. Then every operand is treated as unboxed.
- Classification is on bits [W-1:0]:
  - normal: exp ≠ 0 and exp ≠ all-ones.
  - zero: exp = 0 and mant = 0.
  - subnormal: exp = 0 and mant ≠ 0.
  - inf: exp = all-ones and mant = 0.
  - nan: exp = all-ones and mant ≠ 0, OR the operand is unboxed.
  - signalling: boxed, nan, and mant MSB = 0.
  - quiet: nan and not signalling.
  - Every flag except nan/quiet is gated by `is_boxed`.
- Unboxed operand: canonical qNaN, `class_o` = 10'h200, sign ignored.
- `class_o` bits:
  - 0 −inf, 1 −normal, 2 −subnormal, 3 −zero.
  - 4 +zero, 5 +subnormal, 6 +normal, 7 +inf.
  - 8 sNaN, 9 qNaN.
  - Exactly one bit is set.
- Classification is combinational at the input. Every stage registers `info`, `class`, `fmt_err` and `tag` together.

## Timing
- Latency: exactly `NumPipeRegs` cycles from accept to `out_valid_o` when there is no backpressure. Throughput: 1 transaction/cycle.
- Stage k loads when it is empty or stage k+1 (or downstream) accepts in the same cycle. `in_ready_o` = stage-0 load enable. The chain is fully pipelined: a full chain with `out_ready_i`=1 accepts every cycle.
- Once `out_valid_o` is raised, outputs stay stable until `out_ready_i`; valid never drops without a handshake, except on flush or reset.
- `NumPipeRegs`=0: `out_valid_o`=`in_valid_i`, `in_ready_o`=`out_ready_i`, outputs are combinational.
- Reset (`rst_i` high at a clock edge):
  - All stage valids clear.
  - All data registers go to 0, so `info_o`, `class_o`, `tag_o`, `fmt_err_o` read 0.
  - `out_valid_o`=0, `busy_o`=0.
  - `in_ready_o` is forced 0 while `rst_i` is high and is 1 on the first cycle after.
  - Reset mid-transaction drops the transaction silently.
- `flush_i`: all valids clear at the next edge. No input is accepted in a flush cycle (`in_ready_o`=0). Flush has priority over simultaneous handshakes; an output handshake completing in that cycle still counts.
- `busy_o` = OR of stage valids; combinational.

## Structure
- Additions to `fpnew_pkg`:
  - `classmask_t` (logic [9:0]) and the bit-index constants.
  - `fclass_encode(fp_info_t, sign)`.
  - `is_enabled_fmt(mask, fmt)`.
  - Reuse the existing `fp_width`/`exp_bits`/`man_bits` functions.
- Sub-module `fpnew_elastic_stage`: one valid/ready register slice, parametrised on payload width, with `flush_i` and sync reset. It is instantiated `NumPipeRegs` times via generate.
- Per-format decode is generated over the enabled formats and muxed by `src_fmt_i`.

## Test plan
- FLEN=64, FP32, operand 64'hFFFFFFFF_3F800000 → `is_boxed`=1, `class_o`=10'h040. Operand 64'h00000000_3F800000 → `is_boxed`=0, `class_o`=10'h200, `is_quiet`=1.
- FP64 64'h8000000000000000 → 10'h008. FP64 64'h7FF0000000000001 → 10'h100, `is_signalling`=1. FP64 64'hFFF0000000000000 → 10'h001.
- Formats, boxed:
  - FP16 ...FFFF_0001 → 10'h020.
  - FP8 ...FF_FC → 10'h001.
  - FP16ALT ...FFFF_7FC0 → 10'h200.
- FpFmtMask=5'b00001 with `src_fmt`=FP64 → `fmt_err_o`=1, all classes 10'h200.
- NumPipeRegs=2, 10 back-to-back transactions with tags 0..9, `out_ready_i` low on cycles 3–6. Required:
  - no loss or duplication;
  - tags emerge in order;
  - outputs stable while stalled;
  - first result 2 cycles after first accept.
- Flush and reset:
  - `flush_i` with 2 in flight → `out_valid_o`=0 and `busy_o`=0 next cycle; the next accepted tag emerges normally.
  - `rst_i` mid-stream → all outputs 0; `in_ready_o`=1 the cycle after release.
